// File: rtl/vscale_dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// vscale_dmem_bridge_if : core-side and bus-side signal bundle of the bridge
// Revision: 1.0
// ============================================================================
interface vscale_dmem_bridge_if #(
  parameter int CORE_IDX_WIDTH = 2,
  parameter int ADDR_WIDTH     = 32
);
  // core side
  logic                      dmem_en;
  logic                      dmem_wen;
  logic [2:0]                dmem_size;
  logic [ADDR_WIDTH-1:0]     dmem_addr;
  logic [ADDR_WIDTH-1:0]     dmem_wdata_delayed;
  logic                      dmem_wait;
  logic [ADDR_WIDTH-1:0]     dmem_rdata;
  logic                      dmem_badmem_e;
  // bus side
  logic                      bus_req_valid;
  logic                      bus_req_wen;
  logic [ADDR_WIDTH-1:0]     bus_req_addr;
  logic [3:0]                bus_req_byte_en;
  logic [ADDR_WIDTH-1:0]     bus_req_wdata;
  logic [CORE_IDX_WIDTH-1:0] bus_req_core_id;
  logic                      bus_req_ready;
  logic                      bus_resp_valid;
  logic [ADDR_WIDTH-1:0]     bus_resp_rdata;
  logic                      bus_resp_err;

  // The bridge itself
  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_wait, dmem_rdata, dmem_badmem_e,
    output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_byte_en,
    output bus_req_wdata, bus_req_core_id,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

  // The core plus memory system surrounding the bridge
  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_wait, dmem_rdata, dmem_badmem_e,
    input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_byte_en,
    input  bus_req_wdata, bus_req_core_id,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );
endinterface
`default_nettype wire

// File: rtl/vscale_dmem_bridge.sv
`default_nettype none
// ============================================================================
// vscale_dmem_bridge : turns V-Scale DX-stage dmem accesses into tagged
//                      valid/ready bus requests with single-response completion
// Revision: 1.0
// ============================================================================
module vscale_dmem_bridge #(
  parameter int CORE_IDX_WIDTH = 2,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CORE_IDX_WIDTH-1:0] core_id,
  vscale_dmem_bridge_if.slave       io
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     wdata_q;
  logic [ADDR_WIDTH-1:0]     rdata_q;
  logic [1:0]                size_q;
  logic [CORE_IDX_WIDTH-1:0] core_id_q;
  logic                      wen_q;
  logic                      err_q;

  logic                      accept;
  logic                      resp_take;
  logic                      misaligned;
  logic [3:0]                byte_en;
  logic [ADDR_WIDTH-1:0]     wdata_rep;

  // Size bit 2 (sign/unsigned) matters only to the core's load extension.
  logic unused_size_msb;
  assign unused_size_msb = io.dmem_size[2];

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    wdata_rep  = wdata_q;
    case (size_q)
      2'd0: begin
        byte_en   = 4'b0001 << addr_q[1:0];
        wdata_rep = {(ADDR_WIDTH/8){wdata_q[7:0]}};
      end
      2'd1: begin
        misaligned = addr_q[0];
        byte_en    = 4'b0011 << addr_q[1:0];
        wdata_rep  = {(ADDR_WIDTH/16){wdata_q[15:0]}};
      end
      2'd2: misaligned = |addr_q[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    accept             = 1'b0;
    resp_take          = 1'b0;
    io.dmem_wait       = 1'b0;
    io.dmem_rdata      = '0;
    io.dmem_badmem_e   = 1'b0;
    io.bus_req_valid   = 1'b0;
    io.bus_req_wen     = 1'b0;
    io.bus_req_addr    = '0;
    io.bus_req_byte_en = 4'b0000;
    io.bus_req_wdata   = '0;
    io.bus_req_core_id = '0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          io.dmem_rdata    = rdata_q;
          io.dmem_badmem_e = err_q;
        end
        if (io.dmem_en) begin
          accept    = 1'b1;
          state_nxt = DATA;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        io.dmem_wait = 1'b1;
        state_nxt    = misaligned ? DONE : REQ;
      end
      REQ: begin
        // Fields come only from latched registers, so they hold until the handshake.
        io.dmem_wait       = 1'b1;
        io.bus_req_valid   = 1'b1;
        io.bus_req_wen     = wen_q;
        io.bus_req_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        io.bus_req_byte_en = byte_en;
        io.bus_req_wdata   = wdata_rep;
        io.bus_req_core_id = core_id_q;
        if (io.bus_req_ready) state_nxt = RESP;
      end
      RESP: begin
        io.dmem_wait = 1'b1;
        if (io.bus_resp_valid) begin
          resp_take = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= 2'd0;
      core_id_q <= '0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= io.dmem_addr;
        wen_q     <= io.dmem_wen;
        size_q    <= io.dmem_size[1:0];
        core_id_q <= core_id;
        wdata_q   <= '0;
        rdata_q   <= '0;
        err_q     <= 1'b0;
      end
      if (state == DATA) begin
        if (wen_q)      wdata_q <= io.dmem_wdata_delayed;
        if (misaligned) err_q   <= 1'b1;
      end
      if (resp_take) begin
        rdata_q <= io.bus_resp_rdata;
        err_q   <= io.bus_resp_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vscale_dmem_bridge.md
VSCALE_DMEM_BRIDGE -- requirements
Module: vscale_dmem_bridge

Interface
REQ-001 The block SHALL have parameter CORE_IDX_WIDTH, default 2, the core-identifier width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, the address and data width (XPR_LEN).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, the synchronous active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port core_id, input, CORE_IDX_WIDTH, tagged onto every bus request.
REQ-007 The block SHALL have core-side inputs:
- dmem_en (1): access request in DX.
- dmem_wen (1): store.
- dmem_size (3): [1:0] 0=byte, 1=half, 2=word, 3=reserved.
- dmem_addr (32).
- dmem_wdata_delayed (32): store data, valid the cycle after the request.
REQ-008 The block SHALL have core-side outputs dmem_wait (1), dmem_rdata (32) and dmem_badmem_e (1).
REQ-009 The block SHALL have bus-side outputs bus_req_valid (1), bus_req_wen (1), bus_req_addr (32, word-aligned), bus_req_byte_en (4), bus_req_wdata (32) and bus_req_core_id (CORE_IDX_WIDTH).
REQ-010 The block SHALL have bus-side inputs bus_req_ready (1), bus_resp_valid (1), bus_resp_rdata (32) and bus_resp_err (1).

Function
REQ-011 The block SHALL implement FSM states IDLE, DATA, REQ, RESP and DONE.
REQ-012 In IDLE or DONE, dmem_en=1 SHALL latch addr, wen, size and core_id and move to DATA; otherwise IDLE/DONE SHALL go to IDLE.
REQ-013 dmem_en SHALL be ignored in DATA, REQ and RESP.
REQ-014 DATA SHALL latch dmem_wdata_delayed when wen=1.
REQ-015 If the latched access is misaligned, DATA SHALL go to DONE with error=1 and issue no bus request.
- Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size=3.
REQ-016 Otherwise DATA SHALL go to REQ.
REQ-017 REQ SHALL assert bus_req_valid; REQ SHALL go to RESP in the cycle bus_req_valid and bus_req_ready are both 1.
REQ-018 All bus_req_* fields SHALL be constant while bus_req_valid=1, and bus_req_valid SHALL NOT drop before the handshake.
REQ-019 bus_req_addr SHALL be {addr[31:2],2'b00}.
REQ-020 bus_req_byte_en SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word.
REQ-021 bus_req_wdata SHALL be the latched data replicated: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-022 RESP SHALL wait for bus_resp_valid, then latch bus_resp_rdata and bus_resp_err and go to DONE.
- A response arriving in the same cycle as the request handshake SHALL NOT be accepted; the earliest accepted response is the following cycle.
REQ-023 dmem_wait SHALL be 1 exactly in states DATA, REQ and RESP, and 0 in IDLE and DONE.
REQ-024 In DONE, dmem_rdata SHALL be the latched raw word (no shift or extension) and dmem_badmem_e SHALL equal the latched error.
REQ-025 In all states other than DONE, dmem_rdata SHALL be 0 and dmem_badmem_e SHALL be 0.
REQ-026 Store completions SHALL also pass through DONE, with dmem_rdata=0 unless the bus returns data.
REQ-027 A bus_resp_valid outside RESP SHALL be ignored.
REQ-028 Minimum request-to-completion latency SHALL be 4 cycles.
- Request at cycle T, DATA at T+1, REQ at T+2 with ready at T+2, RESP at T+3 with response at T+3, DONE at T+4.
REQ-029 Back-to-back accesses SHALL be supported: dmem_en in DONE goes directly to DATA with no idle cycle.

Reset
REQ-030 While reset=0, state SHALL be IDLE and all outputs and latched registers SHALL be 0.
REQ-031 Reset asserted in any state SHALL abandon the transaction next edge.
- bus_req_valid SHALL drop, even before a handshake.
- A late response SHALL be dropped per REQ-027.

Verification
REQ-032 Aligned word load, addr 0x104, ready and response immediate, rdata 0xDEADBEEF -> dmem_wait=1 for cycles T+1..T+3; at T+4 dmem_wait=0 and dmem_rdata=0xDEADBEEF.
REQ-033 Store byte, addr 0x203, wdata 0x000000A5 (arriving T+1) -> bus_req_addr=0x200, byte_en=4'b1000, wdata=0xA5A5A5A5, wen=1.
REQ-034 bus_req_ready held 0 for 5 cycles -> bus_req_valid and all bus_req_* fields stable for all 5 cycles; dmem_wait stays 1 until DONE.
REQ-035 Half load at addr 0x101 -> no bus_req_valid; DONE at T+2 with dmem_badmem_e=1.
REQ-036 bus_resp_err=1 -> dmem_badmem_e=1 in DONE only. Back-to-back: dmem_en high in DONE -> DATA the next cycle and a second request issued.
REQ-037 reset=0 while in REQ -> bus_req_valid=0 the next cycle; a subsequent bus_resp_valid is ignored; state IDLE.
